resource_arbiter: RTL and testbench
===================================

RESOURCE_ARBITER -- requirements
Module: resource_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 3: number of layer requesters sharing the RAM and multiplier.
REQ-002 SHALL have parameter NUM_W, default 17: data and multiplier operand width.
REQ-003 SHALL have parameter RAM_ADDR_W, default 8: RAM address width.
REQ-004 SHALL have parameter RAM_DELAY, default 1: RAM read latency in cycles, range 0..7.
REQ-005 SHALL have port clk, input, 1: clock, rising edge.
REQ-006 SHALL have port nreset, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port enable, input, 1: global advance enable.
REQ-008 SHALL have port req, input, REQUESTERS: per-requester access request, level-held.
REQ-009 SHALL have port grant, output, REQUESTERS: one-hot-or-zero ownership.
REQ-010 SHALL have port busy, output, 1: high when the FSM is not in IDLE.
REQ-011 SHALL have ports ram_write_in (REQUESTERS), ram_addr_write_in and ram_addr_read_in (REQUESTERS*RAM_ADDR_W), and ram_data_write_in (REQUESTERS*NUM_W), all inputs: flattened per-requester RAM ports.
REQ-012 SHALL have ports mult_v1_in and mult_v2_in (REQUESTERS*NUM_W) and mult_shift_in (REQUESTERS), all inputs: per-requester multiplier operands.
REQ-013 SHALL have ports ram_write (1), ram_addr_write and ram_addr_read (RAM_ADDR_W), and ram_data_write (NUM_W), all outputs: to the shared RAM.
REQ-014 SHALL have ports mult_v1 and mult_v2 (NUM_W) and mult_shift (1), all outputs: to the shared multiplier.
REQ-015 SHALL have port ram_rd_valid, output, REQUESTERS: one-hot pulse marking RAM read data valid for the issuing requester.

Function
REQ-016 SHALL implement states IDLE, OWNED and DRAIN.
REQ-017 In IDLE, when any req bit is set, SHALL select the first set bit searching upward from rr_ptr with wrap-around, register it into grant at the next edge and enter OWNED; grant latency is 1 cycle.
REQ-018 In OWNED, grant SHALL stay constant while req[owner]=1; changes on non-owner req bits have no effect.
REQ-019 When req[owner]=0 in OWNED, the next edge SHALL clear grant, set rr_ptr=(owner+1) mod REQUESTERS, load drain_cnt=RAM_DELAY and enter DRAIN, or IDLE if RAM_DELAY=0.
REQ-020 DRAIN SHALL decrement drain_cnt each enabled cycle with grant=0 and enter IDLE when drain_cnt reaches 1; new requests wait.
REQ-021 Output muxing SHALL be combinational from the registered grant: the owner's RAM and multiplier inputs drive the outputs; with grant=0, all outputs are 0.
REQ-022 ram_write SHALL equal ram_write_in[owner] & enable; non-owner writes SHALL never reach the RAM.
REQ-023 ram_rd_valid SHALL be grant delayed by RAM_DELAY enabled cycles through a shift pipeline, so read data issued by an owner is tagged to it after release.
REQ-024 With enable=0, the FSM, rr_ptr, drain_cnt and the valid pipeline SHALL hold, and ram_write SHALL be 0.
REQ-025 Owner release and another request in the same cycle SHALL still pass through DRAIN; the new grant issues after DRAIN.
REQ-026 grant SHALL never have more than one bit set.

Reset
REQ-027 When nreset=0, SHALL asynchronously force state=IDLE, grant=0, rr_ptr=0, drain_cnt=0, valid pipeline=0, busy=0 and all muxed outputs to 0, including mid-OWNED and mid-DRAIN.
REQ-028 After reset release, SHALL resume from rr_ptr=0 with no stale ram_rd_valid pulse.

Verification
REQ-029 SHALL verify: req=3'b101 in IDLE -> grant=3'b001 one cycle later; release req[0] -> grant=0, 1 DRAIN cycle, then grant=3'b100.
REQ-030 SHALL verify: owner 1 with ram_write_in=3'b111, ram_addr_write_in[1]=8'h2A -> ram_write=1, ram_addr_write=8'h2A; owner's write dropped -> ram_write=0 despite others at 1.
REQ-031 SHALL verify: owner 2 issues a read in its last owned cycle, RAM_DELAY=1 -> ram_rd_valid=3'b100 in the following cycle (during DRAIN).
REQ-032 SHALL verify: req=3'b111 held with each owner releasing after 4 cycles -> grant order 001, 010, 100, 001.
REQ-033 SHALL verify: enable=0 for 5 cycles while OWNED -> grant unchanged, ram_write=0; nreset pulse mid-DRAIN -> grant=0, busy=0 immediately.
REQ-034 SHALL verify: RAM_DELAY=0, release req[0] with req[1]=1 -> grant=3'b010 two edges after release, with no DRAIN state.

Source files
------------

// File: rtl/resource_arbiter.sv
// resource_arbiter
//   Round-robin arbiter that hands one shared RAM port and one shared
//   multiplier to one of REQUESTERS layer engines at a time. Ownership is
//   held while the owner keeps its request high. After release the arbiter
//   waits RAM_DELAY cycles (DRAIN) so that reads still in flight reach their
//   issuer before the resource changes hands. Read data is tagged to the
//   issuing requester through a grant-delay pipeline (ram_rd_valid).
//
// Ports
//   clk, nreset          clock (rising edge), asynchronous active-low reset
//   enable               global advance enable; all state holds when low
//   req                  per-requester level-held access request
//   grant                one-hot-or-zero ownership (registered)
//   busy                 arbiter not in IDLE
//   ram_*_in             flattened per-requester RAM ports
//   mult_*_in            flattened per-requester multiplier operands
//   ram_*, mult_*        owner's ports muxed to the shared RAM / multiplier
//   ram_rd_valid         grant delayed by RAM_DELAY enabled cycles
module resource_arbiter #(
  parameter int REQUESTERS = 3,
  parameter int NUM_W      = 17,
  parameter int RAM_ADDR_W = 8,
  parameter int RAM_DELAY  = 1
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic                             enable,
  input  logic [REQUESTERS-1:0]            req,
  output logic [REQUESTERS-1:0]            grant,
  output logic                             busy,
  input  logic [REQUESTERS-1:0]            ram_write_in,
  input  logic [REQUESTERS*RAM_ADDR_W-1:0] ram_addr_write_in,
  input  logic [REQUESTERS*RAM_ADDR_W-1:0] ram_addr_read_in,
  input  logic [REQUESTERS*NUM_W-1:0]      ram_data_write_in,
  input  logic [REQUESTERS*NUM_W-1:0]      mult_v1_in,
  input  logic [REQUESTERS*NUM_W-1:0]      mult_v2_in,
  input  logic [REQUESTERS-1:0]            mult_shift_in,
  output logic                             ram_write,
  output logic [RAM_ADDR_W-1:0]            ram_addr_write,
  output logic [RAM_ADDR_W-1:0]            ram_addr_read,
  output logic [NUM_W-1:0]                 ram_data_write,
  output logic [NUM_W-1:0]                 mult_v1,
  output logic [NUM_W-1:0]                 mult_v2,
  output logic                             mult_shift,
  output logic [REQUESTERS-1:0]            ram_rd_valid
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [REQUESTERS-1:0]   grant_nxt;
  logic [REQUESTERS-1:0]   pick;
  logic                    pick_found;
  logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]        owner;
  logic                    owner_req;
  logic [2:0]              drain_cnt, drain_cnt_nxt;
  logic                    ram_write_sel;

  // Round-robin pick: first pass covers rr_ptr..top, second pass wraps to 0.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int j = 0; j < REQUESTERS; j++) begin
      if (!pick_found && req[j] && (j >= int'(rr_ptr))) begin
        pick[j]    = 1'b1;
        pick_found = 1'b1;
      end
    end
    for (int j = 0; j < REQUESTERS; j++) begin
      if (!pick_found && req[j]) begin
        pick[j]    = 1'b1;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    owner = '0;
    for (int j = 0; j < REQUESTERS; j++) begin
      if (grant[j]) owner = PTR_W'(j);
    end
  end

  assign owner_req = |(req & grant);

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    drain_cnt_nxt = drain_cnt;
    if (enable) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_nxt = pick;
            state_nxt = OWNED;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            grant_nxt     = '0;
            rr_ptr_nxt    = (owner == PTR_W'(REQUESTERS - 1)) ? '0 : owner + 1'b1;
            drain_cnt_nxt = 3'(RAM_DELAY);
            state_nxt     = (RAM_DELAY == 0) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          // New requests are ignored here; they are picked up once back in IDLE.
          if (drain_cnt <= 3'd1) begin
            drain_cnt_nxt = '0;
            state_nxt     = IDLE;
          end else begin
            drain_cnt_nxt = drain_cnt - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  assign busy = (state != IDLE);

  // AND-OR mux on the one-hot grant: zero grant gives all-zero outputs.
  always_comb begin
    ram_write_sel  = 1'b0;
    ram_addr_write = '0;
    ram_addr_read  = '0;
    ram_data_write = '0;
    mult_v1        = '0;
    mult_v2        = '0;
    mult_shift     = 1'b0;
    for (int j = 0; j < REQUESTERS; j++) begin
      if (grant[j]) begin
        ram_write_sel  = ram_write_sel | ram_write_in[j];
        ram_addr_write = ram_addr_write | ram_addr_write_in[j*RAM_ADDR_W +: RAM_ADDR_W];
        ram_addr_read  = ram_addr_read  | ram_addr_read_in[j*RAM_ADDR_W +: RAM_ADDR_W];
        ram_data_write = ram_data_write | ram_data_write_in[j*NUM_W +: NUM_W];
        mult_v1        = mult_v1 | mult_v1_in[j*NUM_W +: NUM_W];
        mult_v2        = mult_v2 | mult_v2_in[j*NUM_W +: NUM_W];
        mult_shift     = mult_shift | mult_shift_in[j];
      end
    end
  end

  assign ram_write = ram_write_sel & enable;

  generate
    if (RAM_DELAY == 0) begin : g_no_pipe
      assign ram_rd_valid = grant;
    end else begin : g_pipe
      logic [REQUESTERS-1:0] rd_vld_p [RAM_DELAY];

      // Read-tag pipeline: stage k holds the grant from k+1 enabled cycles ago.
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          for (int k = 0; k < RAM_DELAY; k++) rd_vld_p[k] <= '0;
        end else if (enable) begin
          rd_vld_p[0] <= grant;
          for (int k = 1; k < RAM_DELAY; k++) rd_vld_p[k] <= rd_vld_p[k-1];
        end
      end

      assign ram_rd_valid = rd_vld_p[RAM_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_resource_arbiter.sv
// Testbench for resource_arbiter: directed sequence on a RAM_DELAY=1 instance
// (dut_a) and a RAM_DELAY=0 instance (dut_b) sharing clock, reset and data.
module tb_resource_arbiter;
  localparam int R  = 3;
  localparam int NW = 17;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic nreset;
  logic enable;
  logic [R-1:0]    req, req_b;
  logic [R-1:0]    ram_write_in;
  logic [R*AW-1:0] ram_addr_write_in, ram_addr_read_in;
  logic [R*NW-1:0] ram_data_write_in, mult_v1_in, mult_v2_in;
  logic [R-1:0]    mult_shift_in;

  logic [R-1:0]  grant, ram_rd_valid;
  logic          busy, ram_write, mult_shift;
  logic [AW-1:0] ram_addr_write, ram_addr_read;
  logic [NW-1:0] ram_data_write, mult_v1, mult_v2;

  logic [R-1:0]  grant_b, ram_rd_valid_b;
  logic          busy_b, ram_write_b, mult_shift_b;
  logic [AW-1:0] ram_addr_write_b, ram_addr_read_b;
  logic [NW-1:0] ram_data_write_b, mult_v1_b, mult_v2_b;

  int checks = 0;
  int errors = 0;
  logic [R-1:0] exp_q [$];
  logic [R-1:0] held;

  always #5 clk = ~clk;

  resource_arbiter #(.REQUESTERS(R), .NUM_W(NW), .RAM_ADDR_W(AW), .RAM_DELAY(1)) dut_a (
    .clk(clk), .nreset(nreset), .enable(enable), .req(req),
    .grant(grant), .busy(busy),
    .ram_write_in(ram_write_in), .ram_addr_write_in(ram_addr_write_in),
    .ram_addr_read_in(ram_addr_read_in), .ram_data_write_in(ram_data_write_in),
    .mult_v1_in(mult_v1_in), .mult_v2_in(mult_v2_in), .mult_shift_in(mult_shift_in),
    .ram_write(ram_write), .ram_addr_write(ram_addr_write), .ram_addr_read(ram_addr_read),
    .ram_data_write(ram_data_write), .mult_v1(mult_v1), .mult_v2(mult_v2),
    .mult_shift(mult_shift), .ram_rd_valid(ram_rd_valid)
  );

  resource_arbiter #(.REQUESTERS(R), .NUM_W(NW), .RAM_ADDR_W(AW), .RAM_DELAY(0)) dut_b (
    .clk(clk), .nreset(nreset), .enable(enable), .req(req_b),
    .grant(grant_b), .busy(busy_b),
    .ram_write_in(ram_write_in), .ram_addr_write_in(ram_addr_write_in),
    .ram_addr_read_in(ram_addr_read_in), .ram_data_write_in(ram_data_write_in),
    .mult_v1_in(mult_v1_in), .mult_v2_in(mult_v2_in), .mult_shift_in(mult_shift_in),
    .ram_write(ram_write_b), .ram_addr_write(ram_addr_write_b), .ram_addr_read(ram_addr_read_b),
    .ram_data_write(ram_data_write_b), .mult_v1(mult_v1_b), .mult_v2(mult_v2_b),
    .mult_shift(mult_shift_b), .ram_rd_valid(ram_rd_valid_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with busy-looking inputs: outputs must still be zero.
    nreset            = 1'b0;
    enable            = 1'b1;
    req               = 3'b111;
    req_b             = '0;
    ram_write_in      = '0;
    ram_addr_write_in = '0;
    ram_addr_read_in  = '1;
    ram_data_write_in = '0;
    mult_v1_in        = '0;
    mult_v2_in        = '0;
    mult_shift_in     = '0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_valid", 32'(ram_rd_valid), 0);
    chk("rst_addr_read", 32'(ram_addr_read), 0);
    step();
    step();
    req              = '0;
    ram_addr_read_in = '0;
    nreset           = 1'b1;
    step();

    // Grant latency and round-robin through DRAIN.
    req = 3'b101;
    step();
    chk("grant_first", 32'(grant), 1);
    chk("busy_owned", 32'(busy), 1);
    req = 3'b100;
    step();
    chk("grant_drain", 32'(grant), 0);
    chk("busy_drain", 32'(busy), 1);
    chk("rd_valid_drain0", 32'(ram_rd_valid), 1);
    step();
    chk("grant_idle", 32'(grant), 0);
    chk("busy_idle", 32'(busy), 0);
    step();
    chk("grant_after_drain", 32'(grant), 4);

    // Owner 2 reads in its last owned cycle; tag arrives during DRAIN.
    ram_addr_read_in = 24'h550000;
    #1;
    chk("addr_read_owner2", 32'(ram_addr_read), 'h55);
    req = '0;
    step();
    chk("grant_rel2", 32'(grant), 0);
    chk("rd_valid_owner2", 32'(ram_rd_valid), 4);
    step();
    chk("rd_valid_clear", 32'(ram_rd_valid), 0);

    // Owner 1 write muxing and non-owner isolation.
    req = 3'b010;
    step();
    chk("grant_owner1", 32'(grant), 2);
    ram_write_in              = 3'b111;
    ram_addr_write_in         = 24'h332A11;
    ram_data_write_in         = '0;
    ram_data_write_in[NW +: NW] = 17'h1ABCD;
    mult_v1_in                = '0;
    mult_v1_in[NW +: NW]      = 17'h00123;
    mult_v2_in                = {17'h1FFFF, 17'h00005, 17'h1FFFF};
    mult_shift_in             = 3'b010;
    #1;
    chk("ram_write_owner", 32'(ram_write), 1);
    chk("addr_write_owner", 32'(ram_addr_write), 'h2A);
    chk("data_write_owner", 32'(ram_data_write), 'h1ABCD);
    chk("mult_v1_owner", 32'(mult_v1), 'h123);
    chk("mult_v2_owner", 32'(mult_v2), 'h5);
    chk("mult_shift_owner", 32'(mult_shift), 1);
    ram_write_in = 3'b101;
    #1;
    chk("ram_write_nonowner", 32'(ram_write), 0);

    // enable=0 for 5 cycles: everything holds, writes blocked, even on release.
    ram_write_in = 3'b111;
    enable       = 1'b0;
    #1;
    chk("ram_write_disabled", 32'(ram_write), 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req = '0;
      step();
      chk("grant_hold_disabled", 32'(grant), 2);
      chk("ram_write_hold_disabled", 32'(ram_write), 0);
    end
    enable = 1'b1;
    step();
    chk("grant_rel_enabled", 32'(grant), 0);
    chk("busy_drain2", 32'(busy), 1);
    chk("rd_valid_owner1", 32'(ram_rd_valid), 2);

    // Asynchronous reset mid-DRAIN.
    nreset = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rd_valid", 32'(ram_rd_valid), 0);
    step();
    ram_write_in = '0;
    nreset       = 1'b1;
    step();
    chk("post_rst_rd_valid", 32'(ram_rd_valid), 0);

    // All three requesting; each owner holds 4 cycles then drops its bit.
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (grant == '0 && n < 10);
      if (exp_q.size() == 0) chk("order_queue_empty", 32'(exp_q.size()), 1);
      else chk("grant_order", 32'(grant), 32'(exp_q.pop_front()));
      held = grant;
      for (int c = 0; c < 3; c++) begin
        step();
        chk("owner_hold", 32'(grant), 32'(held));
      end
      req = 3'b111 & ~held;
      step();
      chk("order_release", 32'(grant), 0);
      req = 3'b111;
    end
    req = '0;

    // RAM_DELAY=0: release straight to IDLE, new grant two edges later.
    req_b = 3'b001;
    step();
    chk("b_grant0", 32'(grant_b), 1);
    req_b = 3'b010;
    step();
    chk("b_grant_rel", 32'(grant_b), 0);
    chk("b_busy_no_drain", 32'(busy_b), 0);
    step();
    chk("b_grant1", 32'(grant_b), 2);
    chk("b_rd_valid", 32'(ram_rd_valid_b), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
